// File: rtl/neur_sweep_ctrl.sv
// Timestep sweep controller: issues neuron groups to the LIF pipeline under FIFO credit
// and queues nonzero spike masks. Define NEUR_SWEEP_SPK_COUNT_EN to add the SPK_COUNT output.
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | waiting for TS_START; FIFO may still drain
// S_SWEEP | issuing groups 0..NUM_GROUPS-1, one per cycle while credit allows
// S_DRAIN | all groups issued, waiting for the delay line to empty
// S_DONE  | one-cycle TS_DONE pulse
module neur_sweep_ctrl #(
    parameter int NUM_GROUPS = 64,
    parameter int PIPE_LAT   = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        CLK,
    input  logic        RST_N_sync,
    input  logic        TS_START,
    input  logic [15:0] LIF_neuron_event_out,
    output logic [7:0]  CTRL_NEURMEM_ADDR,
    output logic        CTRL_PIPLINE_START,
    output logic        SPK_VALID,
    input  logic        SPK_READY,
    output logic [7:0]  SPK_ADDR,
    output logic [15:0] SPK_MASK,
    output logic        TS_BUSY,
`ifdef NEUR_SWEEP_SPK_COUNT_EN
    output logic        TS_DONE,
    output logic [10:0] SPK_COUNT
`else
    output logic        TS_DONE
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] LAST_GROUP = 8'(NUM_GROUPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SWEEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [7:0]          issue_addr;
    logic                issue;
    logic                accept;
    logic                credit_ok;

    logic [PIPE_LAT-1:0] dl_valid;
    logic [7:0]          dl_addr [PIPE_LAT];
    logic [7:0]          inflight;
    logic [7:0]          inflight_ahead;

    logic [23:0]         fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;

    // inflight_ahead excludes the slot retiring this cycle, so DRAIN can leave as that slot retires
    always_comb begin
        inflight       = '0;
        inflight_ahead = '0;
        for (int i = 0; i < PIPE_LAT; i++) begin
            inflight = inflight + 8'(dl_valid[i]);
        end
        for (int i = 0; i < PIPE_LAT - 1; i++) begin
            inflight_ahead = inflight_ahead + 8'(dl_valid[i]);
        end
    end

    assign credit_ok = (8'(fifo_count) + inflight) < 8'(FIFO_DEPTH);

    always_ff @(posedge CLK) begin
        if (!RST_N_sync) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                if (TS_START) begin
                    accept    = 1'b1;
                    state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (issue_addr == LAST_GROUP) begin
                        state_nxt = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (inflight_ahead == 8'd0) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign CTRL_PIPLINE_START = issue;
    assign CTRL_NEURMEM_ADDR  = (state == S_SWEEP) ? issue_addr : 8'd0;
    assign TS_BUSY            = (state != S_IDLE);
    assign TS_DONE            = (state == S_DONE);

    always_ff @(posedge CLK) begin
        if (!RST_N_sync) begin
            issue_addr <= '0;
        end else if (accept) begin
            issue_addr <= '0;
        end else if (issue) begin
            issue_addr <= (issue_addr == LAST_GROUP) ? 8'd0 : issue_addr + 8'd1;
        end
    end

    // Delay line mirrors the LIF pipeline so each returning mask can be tagged with its group
    always_ff @(posedge CLK) begin
        if (!RST_N_sync) begin
            dl_valid <= '0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                dl_addr[i] <= '0;
            end
        end else begin
            dl_valid[0] <= issue;
            dl_addr[0]  <= issue_addr;
            for (int i = 1; i < PIPE_LAT; i++) begin
                dl_valid[i] <= dl_valid[i-1];
                dl_addr[i]  <= dl_addr[i-1];
            end
        end
    end

    assign push       = dl_valid[PIPE_LAT-1] && (LIF_neuron_event_out != 16'd0);
    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
    assign pop        = SPK_VALID && SPK_READY;

    assign SPK_VALID           = !fifo_empty;
    assign {SPK_ADDR, SPK_MASK} = fifo_empty ? 24'd0 : fifo_mem[rd_ptr];

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {dl_addr[PIPE_LAT-1], LIF_neuron_event_out};
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N_sync) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

`ifdef NEUR_SWEEP_SPK_COUNT_EN
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + 5'(v[i]);
        end
        return n;
    endfunction

    always_ff @(posedge CLK) begin
        if (!RST_N_sync) begin
            SPK_COUNT <= '0;
        end else if (accept) begin
            SPK_COUNT <= '0;
        end else if (push) begin
            SPK_COUNT <= SPK_COUNT + 11'(popcount16(LIF_neuron_event_out));
        end
    end
`endif

    a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N_sync) !(push && fifo_full));

endmodule

// File: tb/tb_neur_sweep_ctrl.sv
// Directed bench for neur_sweep_ctrl at default parameters; a negedge monitor models the
// LIF pipeline and records issues, pops and TS_DONE for the directed checks.
`timescale 1ns/1ps

module tb_neur_sweep_ctrl;

    localparam int NG = 64;
    localparam int PL = 2;
    localparam int FD = 8;

    logic        CLK = 1'b0;
    logic        RST_N_sync = 1'b0;
    logic        TS_START = 1'b0;
    logic [15:0] LIF_neuron_event_out = 16'd0;
    logic [7:0]  CTRL_NEURMEM_ADDR;
    logic        CTRL_PIPLINE_START;
    logic        SPK_VALID;
    logic        SPK_READY = 1'b1;
    logic [7:0]  SPK_ADDR;
    logic [15:0] SPK_MASK;
    logic        TS_BUSY;
    logic        TS_DONE;
`ifdef NEUR_SWEEP_SPK_COUNT_EN
    logic [10:0] SPK_COUNT;
`endif

    neur_sweep_ctrl #(.NUM_GROUPS(NG), .PIPE_LAT(PL), .FIFO_DEPTH(FD)) dut (
        .CLK                  (CLK),
        .RST_N_sync           (RST_N_sync),
        .TS_START             (TS_START),
        .LIF_neuron_event_out (LIF_neuron_event_out),
        .CTRL_NEURMEM_ADDR    (CTRL_NEURMEM_ADDR),
        .CTRL_PIPLINE_START   (CTRL_PIPLINE_START),
        .SPK_VALID            (SPK_VALID),
        .SPK_READY            (SPK_READY),
        .SPK_ADDR             (SPK_ADDR),
        .SPK_MASK             (SPK_MASK),
        .TS_BUSY              (TS_BUSY),
`ifdef NEUR_SWEEP_SPK_COUNT_EN
        .SPK_COUNT            (SPK_COUNT),
`endif
        .TS_DONE              (TS_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    int mode = 0;
    int cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int done_cnt = 0;
    int issue_cnt = 0;
    int first_issue_cyc = 0;
    int last_issue_cyc = 0;
    int addr_err = 0;
    int valid_seen = 0;
    int mask_err = 0;
    logic [7:0] exp_addr = 8'd0;
    logic [7:0] pop_q [$];

    logic       pv [PL+1];
    logic [7:0] pa [PL+1];

    function automatic logic [15:0] mask_fn(input int m, input logic [7:0] a);
        case (m)
            1:       return (a == 8'd5) ? 16'h0001 : 16'h0000;
            2:       return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Monitor plus LIF model: the mask for an issue seen in cycle t is driven through cycle t+PL
    always @(negedge CLK) begin
        cyc++;
        if (TS_START && !TS_BUSY && RST_N_sync) start_cyc = cyc;
        if (CTRL_PIPLINE_START) begin
            if (issue_cnt == 0) first_issue_cyc = cyc;
            last_issue_cyc = cyc;
            if (CTRL_NEURMEM_ADDR != exp_addr) addr_err++;
            exp_addr = exp_addr + 8'd1;
            issue_cnt++;
        end
        if (SPK_VALID) valid_seen++;
        if (TS_DONE) begin
            if (done_cnt == 0) done_cyc = cyc;
            done_cnt++;
        end
        if (SPK_VALID && SPK_READY) begin
            pop_q.push_back(SPK_ADDR);
            if (SPK_MASK != mask_fn(mode, SPK_ADDR)) mask_err++;
        end
        for (int i = PL; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = CTRL_PIPLINE_START;
        pa[0] = CTRL_NEURMEM_ADDR;
        LIF_neuron_event_out = (pv[PL] === 1'b1) ? mask_fn(mode, pa[PL]) : 16'h0000;
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr_mon();
        issue_cnt  = 0;
        addr_err   = 0;
        exp_addr   = 8'd0;
        valid_seen = 0;
        done_cnt   = 0;
        mask_err   = 0;
        pop_q.delete();
    endtask

    task automatic pulse_start();
        next_cycle();
        TS_START = 1'b1;
        next_cycle();
        TS_START = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int n;
        n = 0;
        while (done_cnt == 0 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        chk("done_seen", 32'(done_cnt != 0), 1);
    endtask

    initial begin
        int found;
        int ord_err;

        for (int i = 0; i <= PL; i++) begin
            pv[i] = 1'b0;
            pa[i] = 8'd0;
        end

        // reset values
        repeat (3) next_cycle();
        @(negedge CLK);
        chk("rst_start", 32'(CTRL_PIPLINE_START), 0);
        chk("rst_busy",  32'(TS_BUSY), 0);
        chk("rst_done",  32'(TS_DONE), 0);
        chk("rst_valid", 32'(SPK_VALID), 0);
        chk("rst_addr",  32'(CTRL_NEURMEM_ADDR), 0);
        chk("rst_spka",  32'(SPK_ADDR), 0);
        chk("rst_spkm",  32'(SPK_MASK), 0);
`ifdef NEUR_SWEEP_SPK_COUNT_EN
        chk("rst_cnt",   32'(SPK_COUNT), 0);
`endif
        next_cycle();
        RST_N_sync = 1'b1;

        // all-zero masks: full sweep, no events, fixed latency
        mode = 0;
        SPK_READY = 1'b1;
        clr_mon();
        pulse_start();
        wait_done(300);
        chk("z_issues",  32'(issue_cnt), 64);
        chk("z_addrerr", 32'(addr_err), 0);
        chk("z_first",   32'(first_issue_cyc - start_cyc), 1);
        chk("z_consec",  32'(last_issue_cyc - first_issue_cyc), 63);
        chk("z_latency", 32'(done_cyc - start_cyc), 64 + PL + 1);
        repeat (10) next_cycle();
        chk("z_valid",   32'(valid_seen), 0);
        chk("z_donecnt", 32'(done_cnt), 1);

        // single event from group 5
        mode = 1;
        clr_mon();
        pulse_start();
        wait_done(300);
        repeat (10) next_cycle();
        chk("g5_popn",  32'(pop_q.size()), 1);
        chk("g5_addr",  32'((pop_q.size() > 0) ? pop_q[0] : 8'hFF), 5);
        chk("g5_mask",  32'(mask_err), 0);
        chk("g5_empty", 32'(SPK_VALID), 0);
`ifdef NEUR_SWEEP_SPK_COUNT_EN
        chk("g5_cnt",   32'(SPK_COUNT), 1);
`endif

        // all-ones masks with a stalled consumer: credit limit, then pop/push at count 7
        mode = 2;
        SPK_READY = 1'b0;
        clr_mon();
        pulse_start();
        repeat (30) next_cycle();
        @(negedge CLK);
        chk("st_issues", 32'(issue_cnt), 8);
        chk("st_start",  32'(CTRL_PIPLINE_START), 0);
        chk("st_hold",   32'(CTRL_NEURMEM_ADDR), 8);
        chk("st_valid",  32'(SPK_VALID), 1);
        chk("st_head",   32'(SPK_ADDR), 0);
        chk("st_mask",   32'(SPK_MASK), 32'h0000FFFF);
        next_cycle();
        SPK_READY = 1'b1;
        next_cycle();
        SPK_READY = 1'b0;
        next_cycle();
        next_cycle();
        SPK_READY = 1'b1;
        @(negedge CLK);
        chk("pp_nostart", 32'(CTRL_PIPLINE_START), 0);
        chk("pp_head1",   32'(SPK_ADDR), 1);
        next_cycle();
        SPK_READY = 1'b0;
        @(negedge CLK);
        chk("pp_start",   32'(CTRL_PIPLINE_START), 1);
        chk("pp_addr9",   32'(CTRL_NEURMEM_ADDR), 9);
        chk("pp_head2",   32'(SPK_ADDR), 2);
        next_cycle();
        @(negedge CLK);
        chk("pp_full",    32'(CTRL_PIPLINE_START), 0);
        next_cycle();
        SPK_READY = 1'b1;
        wait_done(1000);
        repeat (20) next_cycle();
        ord_err = 0;
        for (int i = 0; i < pop_q.size(); i++) begin
            if (pop_q[i] != 8'(i)) ord_err++;
        end
        chk("ff_popn",   32'(pop_q.size()), 64);
        chk("ff_order",  32'(ord_err), 0);
        chk("ff_mask",   32'(mask_err), 0);
        chk("ff_issues", 32'(issue_cnt), 64);
        chk("ff_valid",  32'(SPK_VALID), 0);
`ifdef NEUR_SWEEP_SPK_COUNT_EN
        chk("ff_cnt",    32'(SPK_COUNT), 1024);
`endif

        // reset at group 30 aborts the sweep
        mode = 0;
        clr_mon();
        pulse_start();
        found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge CLK);
            if (CTRL_PIPLINE_START && CTRL_NEURMEM_ADDR == 8'd30) found = 1;
        end
        chk("ab_found", 32'(found), 1);
        next_cycle();
        RST_N_sync = 1'b0;
        next_cycle();
        RST_N_sync = 1'b1;
        @(negedge CLK);
        chk("ab_start", 32'(CTRL_PIPLINE_START), 0);
        chk("ab_busy",  32'(TS_BUSY), 0);
        chk("ab_done",  32'(TS_DONE), 0);
        chk("ab_valid", 32'(SPK_VALID), 0);
        chk("ab_addr",  32'(CTRL_NEURMEM_ADDR), 0);
        repeat (20) next_cycle();
        chk("ab_nodone", 32'(done_cnt), 0);
        clr_mon();
        pulse_start();
        wait_done(300);
        chk("ab_issues", 32'(issue_cnt), 64);
        chk("ab_addrerr", 32'(addr_err), 0);
        repeat (10) next_cycle();

        // TS_START during SWEEP and DRAIN is ignored
        clr_mon();
        pulse_start();
        repeat (9) next_cycle();
        TS_START = 1'b1;
        next_cycle();
        TS_START = 1'b0;
        repeat (54) next_cycle();
        TS_START = 1'b1;
        @(negedge CLK);
        chk("ig_drain", 32'({TS_BUSY, CTRL_PIPLINE_START}), 32'b10);
        next_cycle();
        TS_START = 1'b0;
        wait_done(300);
        chk("ig_latency", 32'(done_cyc - start_cyc), 64 + PL + 1);
        chk("ig_issues",  32'(issue_cnt), 64);
        chk("ig_addrerr", 32'(addr_err), 0);
        repeat (50) next_cycle();
        chk("ig_donecnt", 32'(done_cnt), 1);
        chk("ig_idle",    32'(TS_BUSY), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
